// File: rtl/ifu_arb_pkg.sv
// Shared types and constants for the fetch/load AXI read-channel arbiter.
package ifu_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    typedef logic arb_src_t;

    // Source tag occupies the ARID/RID MSB: bit position is ID_WIDTH - TAG_MSB_OFS.
    localparam int unsigned TAG_MSB_OFS = 1;

endpackage : ifu_arb_pkg

// File: rtl/rd_outst_cnt.sv
// Saturating up/down outstanding-burst counter with full flag and underflow pulse.
module rd_outst_cnt #(
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned CNT_W     = $clog2(MAX_OUTST + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             full_c,
    output logic             underflow_c
);

    assign full_c      = (cnt >= CNT_W'(MAX_OUTST));
    assign underflow_c = dec & (cnt == '0);

    // Simultaneous inc/dec cancel; both directions saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            case ({inc, dec})
                2'b10: if (!full_c)      cnt <= cnt + CNT_W'(1);
                2'b01: if (cnt != '0)    cnt <= cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule : rd_outst_cnt

// File: rtl/ifu_rd_arbiter.sv
// Round-robin AR arbiter between fetch (0) and load (1) with tag-based R routing
// and per-requester outstanding-burst credit tracking.
module ifu_rd_arbiter
    import ifu_arb_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MAX_OUTST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] s0_araddr,
    input  logic [ID_WIDTH-1:0]   s0_arid,
    input  logic [7:0]            s0_arlen,
    input  logic [2:0]            s0_arsize,
    input  logic [1:0]            s0_arburst,
    input  logic                  s0_arvalid,
    output logic                  s0_arready,
    output logic [ID_WIDTH-1:0]   s0_rid,
    output logic [DATA_WIDTH-1:0] s0_rdata,
    output logic [1:0]            s0_rresp,
    output logic                  s0_rlast,
    output logic                  s0_rvalid,
    input  logic                  s0_rready,

    input  logic [ADDR_WIDTH-1:0] s1_araddr,
    input  logic [ID_WIDTH-1:0]   s1_arid,
    input  logic [7:0]            s1_arlen,
    input  logic [2:0]            s1_arsize,
    input  logic [1:0]            s1_arburst,
    input  logic                  s1_arvalid,
    output logic                  s1_arready,
    output logic [ID_WIDTH-1:0]   s1_rid,
    output logic [DATA_WIDTH-1:0] s1_rdata,
    output logic [1:0]            s1_rresp,
    output logic                  s1_rlast,
    output logic                  s1_rvalid,
    input  logic                  s1_rready,

    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [ID_WIDTH-1:0]   m_arid,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [ID_WIDTH-1:0]   m_rid,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready,

    output logic                  idle_o,
    output logic                  err_o
);

    localparam int unsigned TAG_BIT = ID_WIDTH - TAG_MSB_OFS;
    localparam int unsigned CNT_W   = $clog2(MAX_OUTST + 1);

    arb_state_e       state, state_nxt;
    arb_src_t         prio_ptr, prio_nxt;
    arb_src_t         gnt, gnt_nxt;
    arb_src_t         src_pick;
    arb_src_t         r_sel;
    logic             ld;
    logic             arvalid_nxt;
    logic             inc0, inc1, dec0, dec1;
    logic             full0, full1, uf0, uf1;
    logic             elig0, elig1;
    logic [CNT_W-1:0] cnt0, cnt1;
    logic             unused_id_msb;

    // Requesters never drive the tag bit.
    assign unused_id_msb = s0_arid[TAG_BIT] ^ s1_arid[TAG_BIT];

    assign elig0 = s0_arvalid & ~full0;
    assign elig1 = s1_arvalid & ~full1;

    always_comb begin
        state_nxt   = state;
        prio_nxt    = prio_ptr;
        gnt_nxt     = gnt;
        arvalid_nxt = m_arvalid;
        src_pick    = (elig0 && elig1) ? prio_ptr : arb_src_t'(elig1);
        ld          = 1'b0;
        s0_arready  = 1'b0;
        s1_arready  = 1'b0;
        inc0        = 1'b0;
        inc1        = 1'b0;
        case (state)
            IDLE: begin
                if (elig0 || elig1) begin
                    s0_arready  = ~src_pick;
                    s1_arready  = src_pick;
                    ld          = 1'b1;
                    gnt_nxt     = src_pick;
                    arvalid_nxt = 1'b1;
                    state_nxt   = HOLD;
                end
            end
            HOLD: begin
                if (m_arready) begin
                    inc0        = ~gnt;
                    inc1        = gnt;
                    prio_nxt    = ~gnt;
                    arvalid_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            prio_ptr <= 1'b0;
            gnt      <= 1'b0;
        end else begin
            state    <= state_nxt;
            prio_ptr <= prio_nxt;
            gnt      <= gnt_nxt;
        end
    end

    // Payload only loads in IDLE, so it is frozen while m_arvalid is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_araddr  <= '0;
            m_arid    <= '0;
            m_arlen   <= '0;
            m_arsize  <= '0;
            m_arburst <= '0;
            m_arvalid <= 1'b0;
        end else begin
            m_arvalid <= arvalid_nxt;
            if (ld) begin
                m_araddr  <= src_pick ? s1_araddr  : s0_araddr;
                m_arid    <= {src_pick, src_pick ? s1_arid[TAG_BIT-1:0] : s0_arid[TAG_BIT-1:0]};
                m_arlen   <= src_pick ? s1_arlen   : s0_arlen;
                m_arsize  <= src_pick ? s1_arsize  : s0_arsize;
                m_arburst <= src_pick ? s1_arburst : s0_arburst;
            end
        end
    end

    // R channel: zero-latency routing by the tag bit.
    assign r_sel     = m_rid[TAG_BIT];
    assign m_rready  = r_sel ? s1_rready : s0_rready;
    assign s0_rvalid = m_rvalid & ~r_sel;
    assign s1_rvalid = m_rvalid &  r_sel;
    assign s0_rid    = {1'b0, m_rid[TAG_BIT-1:0]};
    assign s1_rid    = {1'b0, m_rid[TAG_BIT-1:0]};
    assign s0_rdata  = m_rdata;
    assign s1_rdata  = m_rdata;
    assign s0_rresp  = m_rresp;
    assign s1_rresp  = m_rresp;
    assign s0_rlast  = m_rlast;
    assign s1_rlast  = m_rlast;

    assign dec0 = m_rvalid & m_rready & m_rlast & ~r_sel;
    assign dec1 = m_rvalid & m_rready & m_rlast &  r_sel;

    rd_outst_cnt #(.MAX_OUTST(MAX_OUTST), .CNT_W(CNT_W)) u_cnt0 (
        .clk(clk), .rst(rst), .inc(inc0), .dec(dec0),
        .cnt(cnt0), .full_c(full0), .underflow_c(uf0)
    );

    rd_outst_cnt #(.MAX_OUTST(MAX_OUTST), .CNT_W(CNT_W)) u_cnt1 (
        .clk(clk), .rst(rst), .inc(inc1), .dec(dec1),
        .cnt(cnt1), .full_c(full1), .underflow_c(uf1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_o <= 1'b0;
        else     err_o <= err_o | uf0 | uf1;
    end

    assign idle_o = (cnt0 == '0) && (cnt1 == '0) && (state == IDLE) && !m_arvalid;

endmodule : ifu_rd_arbiter

// File: tb/tb_ifu_rd_arbiter.sv
// Directed self-checking bench for ifu_rd_arbiter.
module tb_ifu_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s0_araddr, s1_araddr, m_araddr;
    logic [3:0]  s0_arid, s1_arid, m_arid;
    logic [7:0]  s0_arlen, s1_arlen, m_arlen;
    logic [2:0]  s0_arsize, s1_arsize, m_arsize;
    logic [1:0]  s0_arburst, s1_arburst, m_arburst;
    logic        s0_arvalid, s1_arvalid, m_arvalid;
    logic        s0_arready, s1_arready, m_arready;
    logic [3:0]  s0_rid, s1_rid, m_rid;
    logic [63:0] s0_rdata, s1_rdata, m_rdata;
    logic [1:0]  s0_rresp, s1_rresp, m_rresp;
    logic        s0_rlast, s1_rlast, m_rlast;
    logic        s0_rvalid, s1_rvalid, m_rvalid;
    logic        s0_rready, s1_rready, m_rready;
    logic        idle_o, err_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ifu_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .s0_araddr(s0_araddr), .s0_arid(s0_arid), .s0_arlen(s0_arlen),
        .s0_arsize(s0_arsize), .s0_arburst(s0_arburst), .s0_arvalid(s0_arvalid),
        .s0_arready(s0_arready), .s0_rid(s0_rid), .s0_rdata(s0_rdata),
        .s0_rresp(s0_rresp), .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s1_araddr(s1_araddr), .s1_arid(s1_arid), .s1_arlen(s1_arlen),
        .s1_arsize(s1_arsize), .s1_arburst(s1_arburst), .s1_arvalid(s1_arvalid),
        .s1_arready(s1_arready), .s1_rid(s1_rid), .s1_rdata(s1_rdata),
        .s1_rresp(s1_rresp), .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .idle_o(idle_o), .err_o(err_o)
    );

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic quiet();
        s0_arvalid = 1'b0; s1_arvalid = 1'b0;
        m_rvalid = 1'b0; m_rlast = 1'b0; m_rid = 4'h0;
        m_rdata = 64'h0; m_rresp = 2'b00;
        s0_rready = 1'b0; s1_rready = 1'b0; m_arready = 1'b0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [48:0] held;
        rst = 1'b1;
        quiet();
        s0_araddr = 32'h1000_0000; s0_arid = 4'h1; s0_arlen = 8'd3; s0_arsize = 3'd3; s0_arburst = 2'd1;
        s1_araddr = 32'h2000_0000; s1_arid = 4'h2; s1_arlen = 8'd0; s1_arsize = 3'd2; s1_arburst = 2'd1;

        // Reset state
        tick(); #1;
        expect_eq("rst_arvalid", 64'(m_arvalid), 64'd0);
        expect_eq("rst_araddr",  64'(m_araddr),  64'd0);
        expect_eq("rst_idle",    64'(idle_o),    64'd1);
        expect_eq("rst_err",     64'(err_o),     64'd0);
        expect_eq("rst_arready", 64'({s0_arready, s1_arready}), 64'd0);
        rst = 1'b0;

        // Alternating grants: s0, s1, s0, s1
        tick();
        s0_arvalid = 1'b1; s1_arvalid = 1'b1; m_arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            expect_eq("alt_arready", 64'({s0_arready, s1_arready}), (i % 2 == 0) ? 64'b10 : 64'b01);
            expect_eq("alt_arvalid_lo", 64'(m_arvalid), 64'd0);
            tick(); #1;
            expect_eq("alt_arvalid_hi", 64'(m_arvalid), 64'd1);
            expect_eq("alt_arid", 64'(m_arid), (i % 2 == 0) ? 64'h1 : 64'hA);
            tick();
        end
        s0_arvalid = 1'b0; s1_arvalid = 1'b0; #1;
        expect_eq("alt_cnt0", 64'(dut.cnt0), 64'd2);
        expect_eq("alt_cnt1", 64'(dut.cnt1), 64'd2);

        // Credit limit: four s0 grants fill its credits, then s1 still proceeds
        do_reset();
        s0_arvalid = 1'b1; m_arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            expect_eq("cred_s0_gnt", 64'(s0_arready), 64'd1);
            tick(); tick();
        end
        s1_arvalid = 1'b1; #1;
        expect_eq("cred_cnt0_full", 64'(dut.cnt0), 64'd4);
        expect_eq("cred_s0_blocked", 64'({s0_arready, s1_arready}), 64'b01);
        tick(); #1;
        expect_eq("cred_s1_arid", 64'(m_arid), 64'hA);
        s1_arvalid = 1'b0;
        tick();
        m_rvalid = 1'b1; m_rid = 4'h0; m_rlast = 1'b1; s0_rready = 1'b1; #1;
        expect_eq("cred_still_blocked", 64'(s0_arready), 64'd0);
        expect_eq("cred_r_s0valid", 64'(s0_rvalid), 64'd1);
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0; #1;
        expect_eq("cred_cnt0_dec", 64'(dut.cnt0), 64'd3);
        expect_eq("cred_s0_resume", 64'(s0_arready), 64'd1);
        s0_arvalid = 1'b0;

        // R routing by tag, rready gating of the decrement
        do_reset();
        s1_arvalid = 1'b1; m_arready = 1'b1;
        tick(); s1_arvalid = 1'b0;
        tick();
        m_rvalid = 1'b1; m_rid = 4'b1011; m_rlast = 1'b1; m_rdata = 64'hDEAD_BEEF_0123_4567;
        m_rresp = 2'b10; s0_rready = 1'b1; s1_rready = 1'b0; #1;
        expect_eq("r_s1_rvalid", 64'(s1_rvalid), 64'd1);
        expect_eq("r_s0_rvalid", 64'(s0_rvalid), 64'd0);
        expect_eq("r_s1_rid",    64'(s1_rid),    64'h3);
        expect_eq("r_s1_rdata",  s1_rdata,       64'hDEAD_BEEF_0123_4567);
        expect_eq("r_s1_rresp",  64'(s1_rresp),  64'd2);
        expect_eq("r_rready_lo", 64'(m_rready),  64'd0);
        tick(); #1;
        expect_eq("r_cnt1_hold", 64'(dut.cnt1), 64'd1);
        s1_rready = 1'b1; #1;
        expect_eq("r_rready_hi", 64'(m_rready), 64'd1);
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0; #1;
        expect_eq("r_cnt1_dec", 64'(dut.cnt1), 64'd0);
        expect_eq("r_err",      64'(err_o),    64'd0);
        expect_eq("r_idle",     64'(idle_o),   64'd1);

        // Simultaneous AR handshake and RLAST on requester 0 at cnt0 = 2
        do_reset();
        s0_arvalid = 1'b1; m_arready = 1'b1;
        tick(); tick(); tick(); tick();
        #1 expect_eq("sim_cnt0_pre", 64'(dut.cnt0), 64'd2);
        tick();
        s0_arvalid = 1'b0;
        m_rvalid = 1'b1; m_rid = 4'h2; m_rlast = 1'b1; s0_rready = 1'b1; #1;
        expect_eq("sim_hold", 64'(m_arvalid), 64'd1);
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0; #1;
        expect_eq("sim_cnt0", 64'(dut.cnt0), 64'd2);

        // Backpressure: payload frozen while m_arready is low
        do_reset();
        s0_araddr = 32'hCAFE_0040; s0_arid = 4'h5; s0_arlen = 8'd7; s0_arsize = 3'd3; s0_arburst = 2'd1;
        s0_arvalid = 1'b1; s1_arvalid = 1'b1;
        tick();
        s0_araddr = 32'h0BAD_0BAD; s0_arid = 4'h6; s0_arlen = 8'd1;
        held = {32'hCAFE_0040, 4'h5, 8'd7, 3'd3, 2'd1};
        for (int i = 0; i < 5; i++) begin
            #1;
            expect_eq("bp_arvalid", 64'(m_arvalid), 64'd1);
            expect_eq("bp_payload", 64'({m_araddr, m_arid, m_arlen, m_arsize, m_arburst}), 64'(held));
            expect_eq("bp_arready", 64'({s0_arready, s1_arready}), 64'd0);
            tick();
        end
        m_arready = 1'b1;
        tick(); #1;
        expect_eq("bp_cnt0", 64'(dut.cnt0), 64'd1);
        expect_eq("bp_next_s1", 64'({s0_arready, s1_arready}), 64'b01);
        s0_arvalid = 1'b0; s1_arvalid = 1'b0;

        // Stray response sets sticky error, reset clears it
        do_reset();
        m_rvalid = 1'b1; m_rid = 4'h0; m_rlast = 1'b1; s0_rready = 1'b1; #1;
        expect_eq("stray_err_pre", 64'(err_o), 64'd0);
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0; #1;
        expect_eq("stray_err", 64'(err_o), 64'd1);
        expect_eq("stray_cnt0", 64'(dut.cnt0), 64'd0);
        tick(); #1;
        expect_eq("stray_sticky", 64'(err_o), 64'd1);
        rst = 1'b1; #1;
        expect_eq("stray_rst_err", 64'(err_o), 64'd0);
        expect_eq("stray_rst_idle", 64'(idle_o), 64'd1);
        tick();
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ifu_rd_arbiter

// File: doc/ifu_rd_arbiter.md
# ifu_rd_arbiter

Two-requester AXI4 read-channel arbiter that shares the single core-side AXI read master port between the instruction fetch path (requester 0) and the load path (requester 1). It accepts AR requests from both, grants round-robin, tags the grant index into the ARID MSB, and registers the winning request onto the shared port. It routes R beats back by that tag and tracks outstanding bursts per requester so neither exceeds its credit limit. It sits between the fetch/load AXI masters and the bus interconnect.

## Interface

- ID_WIDTH, 4: AXI ID width on all ports. Requesters drive only bits [ID_WIDTH-2:0]; the MSB is reserved for the source tag.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 64: read data width.
- MAX_OUTST, 4: maximum outstanding bursts per requester, range 1..15.

Ports:

- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- sN_araddr / sN_arid / sN_arlen / sN_arsize / sN_arburst  in  ADDR_WIDTH / ID_WIDTH / 8 / 3 / 2  requester N AR payload, N∈{0,1}.
- sN_arvalid  in  1  requester N AR valid.
- sN_arready  out  1  requester N AR ready.
- sN_rid / sN_rdata / sN_rresp / sN_rlast  out  ID_WIDTH / DATA_WIDTH / 2 / 1  requester N R payload.
- sN_rvalid  out  1  requester N R valid.
- sN_rready  in  1  requester N R ready.
- m_araddr / m_arid / m_arlen / m_arsize / m_arburst  out  ADDR_WIDTH / ID_WIDTH / 8 / 3 / 2  shared AR payload (registered).
- m_arvalid  out  1  shared AR valid (registered).
- m_arready  in  1  shared AR ready.
- m_rid / m_rdata / m_rresp / m_rlast / m_rvalid  in  ID_WIDTH / DATA_WIDTH / 2 / 1 / 1  shared R channel.
- m_rready  out  1  shared R ready.
- idle_o  out  1  both outstanding counters zero, FSM in IDLE, m_arvalid low.
- err_o  out  1  sticky: an R beat arrived for a requester with zero outstanding bursts.

## Operation

- AR FSM states:
  - IDLE: eligible(N) = sN_arvalid & (cnt[N] < MAX_OUTST). With one requester eligible, grant it. With both eligible, grant the one selected by prio_ptr. The granted sN_arready is driven combinationally high in this cycle. The payload is captured with m_arid = {N, sN_arid[ID_WIDTH-2:0]}, and the FSM moves to HOLD.
  - HOLD: sN_arready is low for both requesters. The m_ar* outputs hold stable until m_arready is high. On the handshake: cnt[g]++, prio_ptr = ~g, return to IDLE.
- A requester whose counter is at MAX_OUTST is never granted. The other requester proceeds unaffected.
- R routing is purely combinational with sel = m_rid[ID_WIDTH-1]:
  - sN_rvalid = m_rvalid & (sel==N).
  - m_rready = s[sel]_rready.
  - sN_rdata, sN_rresp, sN_rlast pass through.
  - sN_rid = {1'b0, m_rid[ID_WIDTH-2:0]}.
- Counter update: on an R handshake with m_rlast high, cnt[sel]--. An increment and a decrement on the same counter in the same cycle leave it unchanged.
- Decrement at cnt==0: the counter saturates at 0 and err_o sets; it clears only on rst.
- Counter width is $clog2(MAX_OUTST+1).

## Timing

- Reset values:
  - FSM = IDLE, prio_ptr = 0 (requester 0 first).
  - cnt[0] = cnt[1] = 0.
  - m_arvalid = 0, m_ar* payload = 0.
  - err_o = 0, idle_o = 1, sN_arready = 0 until the first eligible cycle.
- AR latency: requester handshake in cycle T gives m_arvalid high in T+1. Best-case AR throughput is one request per 2 cycles.
- R path has zero latency; no R buffering.
- rst asserted mid-burst clears all state immediately. In-flight responses after reset are routed normally, and a response hitting a zero counter sets err_o.
- AXI rule: once m_arvalid is high, the payload is not changed or withdrawn before m_arready.

## Structure

- Package ifu_arb_pkg holds:
  - the state enum arb_state_e {IDLE, HOLD};
  - the source-index typedef arb_src_t (1 bit);
  - the localparam for the tag bit position.
- One natural sub-module: rd_outst_cnt. It is a saturating up/down counter with a full flag and an underflow pulse, instantiated twice.

## Test plan

- **Alternating grants:** s0 and s1 both valid from reset, m_arready=1 → grants s0, s1, s0, s1. m_arid MSB alternates 0,1,0,1, with m_arvalid high every other cycle.
- **Credit limit:** MAX_OUTST=4, s0 issues 5 ARs with no R → the 5th sees sN_arready low and s1 is still granted. One RLAST beat with m_rid MSB=0 → s0's 5th AR is accepted within 2 cycles.
- **R routing:** m_rid=4'b1011, rlast=1 → s1_rvalid=1, s1_rid=4'b0011, s0_rvalid=0. m_rready follows s1_rready, and cnt[1] decrements only when s1_rready=1.
- **Simultaneous events:** s0 AR handshake and s0 RLAST in the same cycle with cnt[0]=2 → cnt[0] stays 2.
- **Backpressure:** m_arready low for 5 cycles while in HOLD → m_ar* is stable throughout and sN_arready is low.
- **Stray response:** R beat with rlast and MSB=0 while cnt[0]=0 → err_o rises and stays high, cnt[0] stays 0. rst clears err_o and sets idle_o=1.
